// File: rtl/rf_cap_pkg.sv
// Shared constants and state encoding for the RF capture writer.
package rf_cap_pkg;
    localparam int DATA_W = 16;
    localparam int NUM_CH = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_CAPTURE  = 3'd1;
    localparam state_t ST_PREFETCH = 3'd2;
    localparam state_t ST_DRAIN    = 3'd3;
    localparam state_t ST_DONE     = 3'd4;
endpackage

// File: rtl/rf_chan_buf.sv
// One channel's sample buffer: simple dual-port RAM with a registered read port.
module rf_chan_buf #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Write port and 1-cycle registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/rf_capture_writer.sv
// Captures DEPTH 4-channel sample sets, then drains them channel-major as a
// valid/ready word stream. The per-channel RAM read registers act as the
// output data register; the read address is steered one word ahead on each
// handshake so back-to-back ready sustains one word per cycle.
module rf_capture_writer
    import rf_cap_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] val3,
    input  logic [DATA_W-1:0] val4,
    output logic              inc_count,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [7:0]        drop_cnt
);
    localparam int CHW = $clog2(NUM_CH);
    localparam logic [AW-1:0]  LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CHW-1:0] LAST_CH  = CHW'(NUM_CH - 1);

    state_t         r_state;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CHW-1:0] r_rd_ch;
    logic           r_out_valid;
    logic [7:0]     r_drop_cnt;

    logic [NUM_CH-1:0][DATA_W-1:0] w_vals;
    logic [NUM_CH-1:0][DATA_W-1:0] w_rdata;
    logic           w_wr_en;
    logic           w_last_wr;
    logic           w_hs;
    logic           w_last_word;
    logic           w_re;
    logic [AW-1:0]  w_raddr;

    assign w_vals      = {val4, val3, val2, val1};
    assign w_wr_en     = (r_state == ST_CAPTURE) && in_valid;
    assign w_last_wr   = w_wr_en && (r_wr_ptr == LAST_PTR);
    assign w_hs        = (r_state == ST_DRAIN) && r_out_valid && out_ready;
    assign w_last_word = w_hs && (r_rd_ch == LAST_CH) && (r_rd_ptr == LAST_PTR);
    assign w_re        = (r_state == ST_PREFETCH) || (r_state == ST_DRAIN);

    // Read address: word 0 on prefetch, next word on handshake, else re-read the held word.
    always_comb begin
        w_raddr = r_rd_ptr;
        if (r_state == ST_PREFETCH) w_raddr = '0;
        else if (w_hs)              w_raddr = r_rd_ptr + AW'(1);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rf_chan_buf #(.W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_buf (
            .clk     (clk),
            .i_we    (w_wr_en),
            .i_waddr (r_wr_ptr),
            .i_wdata (w_vals[c]),
            .i_re    (w_re),
            .i_raddr (w_raddr),
            .o_rdata (w_rdata[c])
        );
    end

    // Frame FSM with write/read pointers and output valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_ch     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state  <= ST_CAPTURE;
                        r_wr_ptr <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (in_valid) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        if (w_last_wr) r_state <= ST_PREFETCH;
                    end
                end
                ST_PREFETCH: begin
                    r_state     <= ST_DRAIN;
                    r_out_valid <= 1'b1;
                    r_rd_ch     <= '0;
                    r_rd_ptr    <= '0;
                end
                ST_DRAIN: begin
                    if (w_hs) begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                        if (r_rd_ptr == LAST_PTR) r_rd_ch <= r_rd_ch + CHW'(1);
                        if (w_last_word) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of samples offered while not capturing.
    always_ff @(posedge clk) begin
        if (reset)
            r_drop_cnt <= '0;
        else if (in_valid && (r_state != ST_CAPTURE) && (r_drop_cnt != 8'hFF))
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign inc_count = (r_state == ST_CAPTURE) && !w_last_wr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid ? w_rdata[r_rd_ch] : '0;
    assign busy      = (r_state == ST_CAPTURE) || (r_state == ST_PREFETCH) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign drop_cnt  = r_drop_cnt;
endmodule
